phase_rotator_pipe: RTL

//  Streaming multi-channel bitstream phase rotator; parametrised successor of the

---
 rtl/phase_rotator_pipe.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/phase_rotator_pipe.sv
// -----------------------------------------------------------------------------
// phase_rotator_pipe
//
// Streaming multi-channel bitstream phase rotator. Each channel word is rotated
// right by its own per-beat shift amount:
//   out[i] = in[(i + k) mod BITSTREAM]
// The rotation uses a pipelined barrel shifter behind a valid/ready handshake.
// Barrel level j rotates by 2^j when k[j] is set. It lives in register stage
// floor(j*PIPE_STAGES/K_W). The shift amount travels with the data so that
// later stages can apply their levels.
//
// Parameters
//   BITSTREAM    bits per channel word (power of 2, >= 2)
//   NUM_CH       independent channels sharing one handshake
//   PIPE_STAGES  register stages, 1..$clog2(BITSTREAM); equals latency
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active high
//   in_valid   in   input beat valid
//   in_ready   out  input beat accepted when in_valid & in_ready
//   in_k       in   shift per channel, ch c at [c*K_W +: K_W]
//   in_bits    in   data, ch c at [c*BITSTREAM +: BITSTREAM]
//   out_valid  out  output beat valid
//   out_ready  in   downstream accepts when out_valid & out_ready
//   out_bits   out  rotated data, same packing as in_bits
//   acc_clr    in   clear phase accumulators (PHASE_ROTATOR_ACCUM_EN only)
//
// Optional feature macro: PHASE_ROTATOR_ACCUM_EN
//   When defined, each channel keeps a K_W-bit phase accumulator. The effective
//   shift of an accepted beat is acc + in_k, and the accumulator takes that sum.
//   When undefined, the effective shift is in_k and the acc_clr port is absent.
// -----------------------------------------------------------------------------
module phase_rotator_pipe #(
  parameter int  BITSTREAM   = 64,
  parameter int  NUM_CH      = 2,
  parameter int  PIPE_STAGES = 3,
  localparam int K_W         = $clog2(BITSTREAM)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_CH*K_W-1:0]       in_k,
  input  logic [NUM_CH*BITSTREAM-1:0] in_bits,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CH*BITSTREAM-1:0] out_bits
`ifdef PHASE_ROTATOR_ACCUM_EN
  ,
  input  logic                        acc_clr
`endif
);

  localparam int DW  = NUM_CH * BITSTREAM;
  localparam int KWA = NUM_CH * K_W;

  logic                   adv;
  logic [KWA-1:0]         eff_k;

  logic [PIPE_STAGES-1:0] st_valid;
  logic [DW-1:0]          st_data [PIPE_STAGES];
  logic [KWA-1:0]         st_k    [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] tap_valid;
  logic [DW-1:0]          tap_data [PIPE_STAGES];
  logic [KWA-1:0]         tap_k    [PIPE_STAGES];
  logic [DW-1:0]          nx_data  [PIPE_STAGES];

  // Rotate right by 2^j. The doubled word makes the wrap-around fall out of a
  // plain right shift.
  function automatic logic [BITSTREAM-1:0] rotr_pow2(input logic [BITSTREAM-1:0] d,
                                                     input int j);
    logic [2*BITSTREAM-1:0] dd;
    dd = {d, d} >> (1 << j);
    return dd[BITSTREAM-1:0];
  endfunction

  // Register stage that hosts barrel level j. The levels are spread as evenly
  // as possible across the stages.
  function automatic int level_stage(input int j);
    return (j * PIPE_STAGES) / K_W;
  endfunction

  // The whole pipeline moves in lockstep. It only stops when the output
  // register holds a beat that downstream refuses.
  assign adv       = ~st_valid[PIPE_STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = st_valid[PIPE_STAGES-1];
  assign out_bits  = st_data[PIPE_STAGES-1];

`ifdef PHASE_ROTATOR_ACCUM_EN
  logic           accept;
  logic [K_W-1:0] acc [NUM_CH];

  assign accept = in_valid & adv;

  // A clear that coincides with a beat makes that beat see a zero accumulator.
  always_comb begin : eff_shift
    eff_k = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      eff_k[c*K_W +: K_W] = (acc_clr ? '0 : acc[c]) + in_k[c*K_W +: K_W];
    end
  end

  // The accumulator tracks the shift actually applied. Stalled cycles leave it
  // untouched.
  always_ff @(posedge clk or posedge rst) begin : phase_acc
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else if (accept) begin
      for (int c = 0; c < NUM_CH; c++) acc[c] <= eff_k[c*K_W +: K_W];
    end else if (acc_clr) begin
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end
  end
`else
  assign eff_k = in_k;
`endif

  // Stage 0 is fed from the input port. Every later stage is fed from the
  // register of the stage before it.
  always_comb begin : tap_select
    tap_valid   = '0;
    tap_valid[0] = in_valid;
    tap_data[0]  = in_bits;
    tap_k[0]     = eff_k;
    for (int s = 1; s < PIPE_STAGES; s++) begin
      tap_valid[s] = st_valid[s-1];
      tap_data[s]  = st_data[s-1];
      tap_k[s]     = st_k[s-1];
    end
  end

  // Each stage applies only the barrel levels assigned to it, in every channel.
  always_comb begin : barrel_levels
    for (int s = 0; s < PIPE_STAGES; s++) begin
      nx_data[s] = tap_data[s];
      for (int c = 0; c < NUM_CH; c++) begin
        for (int j = 0; j < K_W; j++) begin
          if (level_stage(j) == s && tap_k[s][c*K_W + j]) begin
            nx_data[s][c*BITSTREAM +: BITSTREAM] =
              rotr_pow2(nx_data[s][c*BITSTREAM +: BITSTREAM], j);
          end
        end
      end
    end
  end

  // Stage registers. A bubble enters as an invalid stage.
  // Reset discards every in-flight beat.
  always_ff @(posedge clk or posedge rst) begin : stage_regs
    if (rst) begin
      st_valid <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        st_data[s] <= '0;
        st_k[s]    <= '0;
      end
    end else if (adv) begin
      st_valid <= tap_valid;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        st_data[s] <= nx_data[s];
        st_k[s]    <= tap_k[s];
      end
    end
  end

endmodule
